// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared state encoding and datapath widths for the CPU clock step controller
package clk_ctrl_pkg;
    typedef enum logic [1:0] {HALTED = 2'd0, RUN = 2'd1, STEP = 2'd2, WAIT_REL = 2'd3} state_t;
    localparam int DIV_W = 32;
    localparam int CNT_W = 32;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter for a raw push-button;
// o_rise marks the clock the debounced level goes high, only once a genuine release has been seen.
module btn_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_db,
    output logic o_rise
);
    localparam logic [DEB_W-1:0] LAST = {{(DEB_W-1){1'b1}}, 1'b0};
    logic             r_sync1, r_sync2, r_live1, r_live2, r_armed, r_db;
    logic [DEB_W-1:0] r_cnt;
    logic             w_differ, w_flip;
    assign w_differ = r_sync2 ^ r_db;
    assign w_flip   = w_differ && (r_cnt == LAST);
    // r_live marks when r_sync2 holds a real sample, so a button held through reset is not taken as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_live1 <= 1'b0;
            r_live2 <= 1'b0;
            r_armed <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_live1 <= 1'b1;
            r_live2 <= r_live1;
            r_armed <= r_armed | (r_live2 & ~r_sync2);
            r_cnt   <= (w_differ && !w_flip) ? r_cnt + DEB_W'(1) : '0;
            r_db    <= w_flip ? r_sync2 : r_db;
        end
    end
    assign o_db   = r_db;
    assign o_rise = w_flip & r_sync2 & r_armed;
endmodule

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: run/step/halt CPU clock-enable generator paced by a free-running divider tap.
// Define CLK_STEP_CTRL_CYCLE_CNT_EN to implement the cpu_ce pulse counter; otherwise cycle_cnt reads 0.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        halt_req,
    input  logic [4:0]  div_sel,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [31:0] clkdiv,
    output logic [31:0] cycle_cnt
);
    state_t           r_state, w_next;
    logic             r_cpu_ce, r_tap_q, w_ce_d, w_tap, w_tap_rise, w_step_db, w_step_rise;
    logic [DIV_W-1:0] r_clkdiv;

    btn_debounce #(.DEB_W(DEB_W)) u_step_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (step),
        .o_db   (w_step_db),
        .o_rise (w_step_rise)
    );

    assign w_tap      = r_clkdiv[div_sel];
    assign w_tap_rise = w_tap & ~r_tap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HALTED;
            r_cpu_ce <= 1'b0;
            r_clkdiv <= '0;
            r_tap_q  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cpu_ce <= w_ce_d;
            r_clkdiv <= r_clkdiv + DIV_W'(1);
            r_tap_q  <= w_tap;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HALTED:   w_next = halt_req ? HALTED : run ? RUN : w_step_rise ? STEP : HALTED;
            RUN:      w_next = (halt_req || !run) ? HALTED : RUN;
            STEP:     w_next = WAIT_REL;
            WAIT_REL: w_next = w_step_db ? WAIT_REL : HALTED;
            default:  w_next = HALTED;
        endcase
    end

    // cpu_ce is registered: high for the whole STEP state, or the clock after a tap edge while staying in RUN
    always_comb begin
        w_ce_d = (w_next == STEP) || (r_state == RUN && w_next == RUN && w_tap_rise);
    end

`ifdef CLK_STEP_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycle_cnt <= '0;
        else        r_cycle_cnt <= r_cycle_cnt + CNT_W'(r_cpu_ce);
    end
    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = '0;
`endif

    assign cpu_ce = r_cpu_ce;
    assign state  = r_state;
    assign clkdiv = r_clkdiv;
endmodule
